// File: rtl/zuc256_io_pkg.sv
// Shared definitions for the ZUC-256 wrapper I/O path: packer states, default
// widths and the bit layout of the wrapper's 1024-bit input word.
package zuc256_io_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } packer_state_t;

    localparam int DEF_IN_W  = 32;
    localparam int DEF_OUT_W = 1024;

    // Field positions inside the right-aligned wrapper input word
    localparam int ENC_AUTH_BIT = 528;
    localparam int KEY_MSB      = 527;
    localparam int KEY_LSB      = 272;
    localparam int IV_MSB       = 271;
    localparam int IV_LSB       = 144;
    localparam int BLOCK_MSB    = 143;
    localparam int BLOCK_LSB    = 16;
    localparam int I_LEN_MSB    = 15;
    localparam int I_LEN_LSB    = 8;
    localparam int TAG_LEN_MSB  = 7;
    localparam int TAG_LEN_LSB  = 0;

    localparam int FRAME_BEATS_MIN = 17;

endpackage

// File: rtl/zuc256_in_packer.sv
// Packs a frame of narrow stream beats into one right-aligned wide word and
// holds it on a valid/ready port until the ZUC-256 wrapper takes it.
module zuc256_in_packer
    import zuc256_io_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    localparam int BEATS = OUT_W / IN_W,
    localparam int CNT_W = $clog2(BEATS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] words_o
);

    packer_state_t    state;
    packer_state_t    state_next;
    logic [OUT_W-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             frame_end;

    assign accept    = s_valid && s_ready;
    // A full word completes the frame even without s_last
    assign frame_end = accept && (s_last || (cnt == CNT_W'(BEATS - 1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_FILL;
            data    <= '0;
            cnt     <= '0;
            words_o <= '0;
        end else begin
            state <= state_next;
            if (clear) begin
                data <= '0;
                cnt  <= '0;
            end else if (accept) begin
                data <= {data[OUT_W-IN_W-1:0], s_data};
                cnt  <= cnt + 1'b1;
                if (frame_end) begin
                    words_o <= cnt + 1'b1;
                end
            end else if (state == ST_HOLD && out_ready) begin
                data <= '0;
                cnt  <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_FILL;
        end else begin
            case (state)
                ST_FILL: if (frame_end) state_next = ST_HOLD;
                ST_HOLD: if (out_ready) state_next = ST_FILL;
                default: state_next = ST_FILL;
            endcase
        end
    end

    always_comb begin
        s_ready   = (state == ST_FILL) && !clear && !reset;
        out_valid = (state == ST_HOLD);
        out_data  = data;
    end

endmodule
